// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman responder.
// Defaults, FSM encoding and public-value validity bounds.
package dh_pkg;

    localparam int N_DEF = 8;
    localparam int P_DEF = 89;
    localparam int G_DEF = 3;

    // A public value v is acceptable when PUB_MIN <= v <= P - PUB_MARGIN.
    localparam int PUB_MIN    = 2;
    localparam int PUB_MARGIN = 2;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PUB_OP,
        SEND,
        SEC_OP
    } state_t;

endpackage

// File: rtl/dh_mulmod.sv
// Combinational modular product (a*b) mod P.
// Full 2N-bit product reduced to N bits.
module dh_mulmod #(
    parameter int N = 8,
    parameter int P = 89
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    localparam logic [2*N-1:0] P_W = (2*N)'(P);

    logic [2*N-1:0] prod;

    assign prod = a * b;
    assign y    = N'(prod % P_W);

endmodule

// File: rtl/dh_responder.sv
// Diffie-Hellman responder: B = G^b mod P, then K = A^b mod P,
// on one shared LSB-first square-and-multiply datapath.
module dh_responder
    import dh_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int P = P_DEF,
    parameter int G = G_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         peer_valid,
    input  logic [N-1:0] peer_pub,
    input  logic [N-1:0] priv_key,
    output logic         peer_ready,
    output logic         pub_valid,
    output logic [N-1:0] pub_key,
    input  logic         pub_ack,
    output logic         key_valid,
    output logic [N-1:0] shared_key,
    output logic         busy,
    output logic         err
);

    localparam logic [N-1:0] G_N    = N'(G);
    localparam logic [N-1:0] PUB_LO = N'(PUB_MIN);
    localparam logic [N-1:0] PUB_HI = N'(P - PUB_MARGIN);
    localparam logic [N-1:0] EXP_HI = N'(P - 1);
    localparam logic [N-1:0] ONE    = N'(1);

    state_t       state, state_n;
    logic [N-1:0] a_q, a_n;
    logic [N-1:0] b_q, b_n;
    logic [N-1:0] base, base_n;
    logic [N-1:0] exp, exp_n;
    logic [N-1:0] acc, acc_n;
    logic [N-1:0] pub_key_n, shared_key_n;
    logic         pub_valid_n, key_valid_n, err_n;
    logic [N-1:0] mul_acc, mul_sq;
    logic         reject;

    dh_mulmod #(.N(N), .P(P)) u_mul_acc (
        .a (acc),
        .b (base),
        .y (mul_acc)
    );

    dh_mulmod #(.N(N), .P(P)) u_mul_sq (
        .a (base),
        .b (base),
        .y (mul_sq)
    );

    assign reject = (a_q < PUB_LO) || (a_q > PUB_HI)
                 || (b_q == '0) || (b_q >= EXP_HI);

    // Ready is suppressed while reset is held so every output reads 0.
    assign peer_ready = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n      = state;
        a_n          = a_q;
        b_n          = b_q;
        base_n       = base;
        exp_n        = exp;
        acc_n        = acc;
        pub_key_n    = pub_key;
        pub_valid_n  = pub_valid;
        shared_key_n = shared_key;
        key_valid_n  = 1'b0;
        err_n        = 1'b0;
        unique case (state)
            IDLE: begin
                if (peer_valid) begin
                    a_n     = peer_pub;
                    b_n     = priv_key;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    base_n  = G_N;
                    exp_n   = b_q;
                    acc_n   = ONE;
                    state_n = PUB_OP;
                end
            end
            PUB_OP, SEC_OP: begin
                if (exp == '0) begin
                    if (state == PUB_OP) begin
                        pub_key_n   = acc;
                        pub_valid_n = 1'b1;
                        state_n     = SEND;
                    end else begin
                        shared_key_n = acc;
                        key_valid_n  = 1'b1;
                        state_n      = IDLE;
                    end
                end else begin
                    if (exp[0]) acc_n = mul_acc;
                    base_n = mul_sq;
                    exp_n  = exp >> 1;
                end
            end
            SEND: begin
                if (pub_ack) begin
                    pub_valid_n = 1'b0;
                    base_n      = a_q;
                    exp_n       = b_q;
                    acc_n       = ONE;
                    state_n     = SEC_OP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            base       <= '0;
            exp        <= '0;
            acc        <= '0;
            pub_key    <= '0;
            pub_valid  <= 1'b0;
            shared_key <= '0;
            key_valid  <= 1'b0;
            err        <= 1'b0;
        end else if (ena) begin
            state      <= state_n;
            a_q        <= a_n;
            b_q        <= b_n;
            base       <= base_n;
            exp        <= exp_n;
            acc        <= acc_n;
            pub_key    <= pub_key_n;
            pub_valid  <= pub_valid_n;
            shared_key <= shared_key_n;
            key_valid  <= key_valid_n;
            err        <= err_n;
        end
    end

endmodule

// File: doc/dh_responder.md
Name: dh_responder

Overview:
- Responder side of the drone Diffie-Hellman key exchange. Accepts the initiator's public value A and holds a local private exponent b.
- Computes its own public value B = G^b mod P and hands B back through a valid/ack handshake.
- Then computes the shared secret K = A^b mod P. Both computations run on one time-shared LSB-first square-and-multiply datapath, one exponent bit per enabled cycle.

Parameters:
- N, 8, width of all operands, keys and exponents (unsigned).
- P, 89, public prime modulus; requires 3 <= P < 2^N.
- G, 3, public generator; requires 2 <= G <= P-2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  clock enable; when low, every register holds, including state, outputs and handshake flags.
- peer_valid  in  1  initiator public value present on peer_pub.
- peer_pub  in  N  initiator public value A.
- priv_key  in  N  local private exponent b; sampled with peer_pub.
- peer_ready  out  1  responder can accept A; high only in IDLE.
- pub_valid  out  1  B is valid on pub_key; held until pub_ack.
- pub_key  out  N  B = G^b mod P.
- pub_ack  in  1  consumer has taken B.
- key_valid  out  1  single-cycle pulse: shared_key is final.
- shared_key  out  N  K = A^b mod P; holds its value until the next accepted request.
- busy  out  1  high in every state except IDLE.
- err  out  1  single-cycle pulse: request rejected.

Behaviour:
- Reset values: all outputs 0, state IDLE. Internal base, exp and acc registers are 0.
- All register updates are qualified by ena. In the descriptions below, "cycle" means an enabled cycle.
- IDLE:
  - peer_ready=1.
  - On peer_valid&peer_ready, capture A=peer_pub and b=priv_key, then go to CHECK.
  - Ignore peer_valid in all other states; peer_ready=0 outside IDLE.
- CHECK (1 cycle): validate the captured inputs.
  - Reject if A<2, A>P-2, b==0, or b>=P-1.
  - On reject: pulse err, return to IDLE, leave pub_key and shared_key unchanged.
  - Otherwise load base=G, exp=b, acc=1, then go to PUB_OP.
- PUB_OP: one step per cycle while exp!=0.
  - If exp[0] is set, acc <= (acc*base) mod P.
  - base <= (base*base) mod P.
  - exp <= exp>>1.
  - When exp==0 at the start of a cycle: pub_key <= acc, pub_valid <= 1, go to SEND. No step is taken that cycle.
- SEND:
  - Hold pub_valid=1 and pub_key stable until pub_ack=1.
  - On that cycle, clear pub_valid, load base=A, exp=b, acc=1, and go to SEC_OP.
  - pub_ack outside SEND is ignored.
- SEC_OP: the same step rule as PUB_OP, operating on A. When exp==0: shared_key <= acc, key_valid pulses for 1 cycle, return to IDLE.
- Latency:
  - Let L = bit length of b.
  - Accept to pub_valid: 1 (CHECK) + L steps + 1 terminating cycle = L+2 cycles.
  - pub_ack to key_valid: L+1 cycles.
- Arithmetic:
  - Products are computed at 2N bits and reduced mod P before being stored.
  - Stored values are always < P, so they never overflow N bits.
- Back-to-back: a new request can be accepted in the cycle after key_valid.
- pub_ack arriving in the same cycle pub_valid first rises is not possible; ack is sampled only while in SEND.
- Reset mid-operation aborts immediately. Every output returns to 0, including shared_key and pub_key, and no key_valid is emitted.
- ena low mid-operation freezes the whole block. A pending key_valid or err pulse is emitted on the next enabled cycle, not lost.

Decomposition:
- Shared package dh_pkg holds:
  - Defaults N_DEF=8, P_DEF=89, G_DEF=3.
  - The state encoding: IDLE, CHECK, PUB_OP, SEND, SEC_OP.
  - The validity bounds for public values.
- One sub-module, dh_mulmod: combinational (a*b) mod P, parameterised by N and P. Two instances are used, one for the acc update and one for the base squaring.

Test Plan:
- Nominal (N=8, P=89, G=3): A=10, b=5 -> pub_key=65 after 5 cycles (L=3); ack -> shared_key=53, key_valid pulse 4 cycles later; peer_ready back to 1.
- Rejections: b=0 -> err pulse, no pub_valid. A=1 -> err pulse. A=88 -> err pulse. b=88 -> err pulse. shared_key keeps its previous value after each.
- Backpressure: hold pub_ack=0 for 20 cycles -> pub_valid and pub_key=65 stay stable; the secret phase starts only after ack.
- Ena gating: toggle ena 50% during PUB_OP for A=10, b=5 -> same results (65, 53); latency counted in enabled cycles only.
- Reset in SEC_OP: assert rst mid-computation -> all outputs 0 at once, state IDLE, no key_valid; a following request with A=10, b=5 gives 53.
- Max exponent: b=87, A=2 -> pub_key=3^87 mod 89=30, shared_key=2^87 mod 89=45 (inverses of G and A by Fermat); L=7.
